// File: rtl/mcs_sdram_bridge_pkg.sv
// Shared types and helpers for the MCS-to-SDRAM command bridge.
package mcs_sdram_bridge_pkg;

   localparam int          WORD_ADDR_W  = 23;
   localparam int          WINDOW_MSB   = 24;
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_WR_ISSUE     = 3'd1,
      ST_RD_ISSUE     = 3'd2,
      ST_RD_WAIT      = 3'd3,
      ST_RMW_RD_ISSUE = 3'd4,
      ST_RMW_RD_WAIT  = 3'd5,
      ST_RMW_WR_ISSUE = 3'd6,
      ST_RESP         = 3'd7
   } state_e;

   // Lanes with their enable set take the new write data, the rest keep the fetched word.
   function automatic logic [31:0] merge_lanes(input logic [31:0] wdata,
                                               input logic [31:0] rdata,
                                               input logic [3:0]  be);
      logic [31:0] merged;
      merged = rdata;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/mcs_sdram_bridge_wdog.sv
// Read-response watchdog: counts cycles spent waiting and flags a sticky error on expiry.
module mcs_sdram_bridge_wdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run_i,
   output logic expired_o,
   output logic err_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   // The counter sits at zero whenever no wait is in progress, so entry always starts from zero.
   assign expired_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign err_o     = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (run_i) cnt_q <= cnt_q + CNT_W'(1);
         else       cnt_q <= '0;
         if (expired_o) err_q <= 1'b1;
      end
   end

endmodule

// File: rtl/mcs_sdram_bridge.sv
// MCS IO-bus to SDRAM controller command bridge with read-modify-write for partial writes.
// Optional read watchdog enabled by defining MCS_SDRAM_BRIDGE_TIMEOUT_EN.
module mcs_sdram_bridge
   import mcs_sdram_bridge_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'hC000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] MISS_DATA      = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   io_addr_strobe,
   input  logic                   io_read_strobe,
   input  logic                   io_write_strobe,
   input  logic [31:0]            io_address,
   input  logic [3:0]             io_byte_enable,
   input  logic [31:0]            io_write_data,
   output logic [31:0]            io_read_data,
   output logic                   io_ready,
   output logic [WORD_ADDR_W-1:0] addr,
   output logic                   rw,
   output logic [31:0]            data_in,
   output logic                   in_valid,
   input  logic                   busy,
   input  logic [31:0]            data_out,
   input  logic                   out_valid,
   output logic                   err
);

   state_e                 state_q;
   logic [WORD_ADDR_W-1:0] addr_q;
   logic                   rw_q;
   logic [31:0]            data_in_q;
   logic [31:0]            wdata_q;
   logic [3:0]             be_q;
   logic [31:0]            io_read_data_q;
   logic                   io_ready_q;

   logic in_window;
   logic is_read;
   logic in_issue;
   logic in_wait;
   logic timeout;
   logic unused_addr_bits;

   assign unused_addr_bits = ^io_address[1:0];
   assign in_window = (io_address[31:WINDOW_MSB+1] == BASE_ADDR[31:WINDOW_MSB+1]);
   assign is_read   = io_read_strobe | ~io_write_strobe;
   assign in_issue  = (state_q == ST_WR_ISSUE) || (state_q == ST_RD_ISSUE) ||
                      (state_q == ST_RMW_RD_ISSUE) || (state_q == ST_RMW_WR_ISSUE);
   assign in_wait   = (state_q == ST_RD_WAIT) || (state_q == ST_RMW_RD_WAIT);

   assign in_valid     = in_issue & ~busy;
   assign addr         = addr_q;
   assign rw           = rw_q;
   assign data_in      = data_in_q;
   assign io_read_data = io_read_data_q;
   assign io_ready     = io_ready_q;

`ifdef MCS_SDRAM_BRIDGE_TIMEOUT_EN
   logic wait_run;
   assign wait_run = in_wait & ~out_valid;

   mcs_sdram_bridge_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .run_i     (wait_run),
      .expired_o (timeout),
      .err_o     (err)
   );
`else
   logic unused_wait;
   assign unused_wait = in_wait;
   assign timeout     = 1'b0;
   assign err         = 1'b0;
`endif

   // RESP lasts two cycles when entered straight from IDLE so no-command accesses
   // complete on the same cycle as a single issued write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         addr_q         <= '0;
         rw_q           <= 1'b0;
         data_in_q      <= '0;
         wdata_q        <= '0;
         be_q           <= '0;
         io_read_data_q <= '0;
         io_ready_q     <= 1'b0;
      end else begin
         io_ready_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (io_addr_strobe) begin
                  addr_q    <= io_address[WINDOW_MSB:2];
                  wdata_q   <= io_write_data;
                  be_q      <= io_byte_enable;
                  data_in_q <= io_write_data;
                  if (!in_window) begin
                     if (is_read) io_read_data_q <= MISS_DATA;
                     state_q <= ST_RESP;
                  end else if (is_read) begin
                     rw_q    <= 1'b0;
                     state_q <= ST_RD_ISSUE;
                  end else if (io_byte_enable == 4'b1111) begin
                     rw_q    <= 1'b1;
                     state_q <= ST_WR_ISSUE;
                  end else if (io_byte_enable == 4'b0000) begin
                     state_q <= ST_RESP;
                  end else begin
                     rw_q    <= 1'b0;
                     state_q <= ST_RMW_RD_ISSUE;
                  end
               end
            end
            ST_WR_ISSUE, ST_RMW_WR_ISSUE: begin
               if (!busy) begin
                  io_ready_q <= 1'b1;
                  state_q    <= ST_RESP;
               end
            end
            ST_RD_ISSUE: begin
               if (!busy) state_q <= ST_RD_WAIT;
            end
            ST_RMW_RD_ISSUE: begin
               if (!busy) state_q <= ST_RMW_RD_WAIT;
            end
            ST_RD_WAIT: begin
               if (out_valid) begin
                  io_read_data_q <= data_out;
                  io_ready_q     <= 1'b1;
                  state_q        <= ST_RESP;
               end else if (timeout) begin
                  io_read_data_q <= TIMEOUT_DATA;
                  io_ready_q     <= 1'b1;
                  state_q        <= ST_RESP;
               end
            end
            ST_RMW_RD_WAIT: begin
               if (out_valid) begin
                  data_in_q <= merge_lanes(wdata_q, data_out, be_q);
                  rw_q      <= 1'b1;
                  state_q   <= ST_RMW_WR_ISSUE;
               end else if (timeout) begin
                  io_ready_q <= 1'b1;
                  state_q    <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (io_ready_q) state_q <= ST_IDLE;
               else            io_ready_q <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
